// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver: soft-start duty ramp, immediate duty drop at period wrap,
// and a dead time that blanks the bridge whenever the direction reverses.
module motor_pwm_driver #(
    parameter int unsigned PERIOD      = 50000,
    parameter int unsigned DEAD_CYCLES = 100000,
    parameter int unsigned RAMP_STEP   = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] width_in,
    input  logic [3:0]  dir_in,
    output logic [3:0]  dir_out,
    output logic        pwm_a,
    output logic        pwm_b,
    output logic [15:0] active_width,
    output logic        busy
);

    localparam int unsigned DW         = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [15:0] PeriodW    = 16'(PERIOD);
    localparam logic [15:0] PeriodLast = 16'(PERIOD - 1);
    localparam logic [15:0] RampW      = (RAMP_STEP > 65535) ? 16'hFFFF : 16'(RAMP_STEP);
    localparam logic [DW-1:0] DeadLoad = DW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   width_q, width_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [3:0]    dir_q, dir_d;
    logic          pwm_q, pwm_d;

    logic          valid_dir, stop, wrap;
    logic [15:0]   target, gap, step;

    assign valid_dir = (dir_in == 4'b0101) || (dir_in == 4'b0110) ||
                       (dir_in == 4'b1010) || (dir_in == 4'b1001);
    assign stop      = !valid_dir || (width_in == 16'd0);
    assign target    = (width_in >= PeriodW) ? PeriodW : width_in;
    // gap is only meaningful when target >= width_q; step never pushes past target
    assign gap       = target - width_q;
    assign step      = (gap < RampW) ? gap : RampW;
    assign wrap      = (cnt_q == PeriodLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (!stop) state_d = StRun;
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (dir_in != dir_q) begin
                    state_d = StDead;
                end
            end
            StDead: if (dead_q == '0) state_d = stop ? StIdle : StRun;
            default: state_d = StIdle;
        endcase
    end

    // Every exit from RUN (and every entry) leaves counter, duty and bridge at zero.
    always_comb begin
        cnt_d   = '0;
        width_d = '0;
        dir_d   = '0;
        dead_d  = dead_q;
        unique case (state_q)
            StRun: begin
                if (state_d == StRun) begin
                    dir_d = dir_q;
                    if (wrap) begin
                        width_d = (target < width_q) ? target : width_q + step;
                    end else begin
                        cnt_d   = cnt_q + 16'd1;
                        width_d = width_q;
                    end
                end else if (state_d == StDead) begin
                    dead_d = DeadLoad;
                end
            end
            StDead: begin
                if (dead_q != '0) dead_d = dead_q - DW'(1);
                if (state_d == StRun) dir_d = dir_in;
            end
            default: begin
                if (state_d == StRun) dir_d = dir_in;
            end
        endcase
        pwm_d = (state_d == StRun) && (cnt_d < width_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            width_q <= '0;
            dead_q  <= '0;
            dir_q   <= '0;
            pwm_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            width_q <= width_d;
            dead_q  <= dead_d;
            dir_q   <= dir_d;
            pwm_q   <= pwm_d;
        end
    end

    assign dir_out      = dir_q;
    assign pwm_a        = pwm_q;
    assign pwm_b        = pwm_q;
    assign active_width = width_q;
    assign busy         = (state_q == StDead);

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Bench for motor_pwm_driver: directed scenarios plus random command streams,
// compared every cycle against a phase/duty reference model.
module tb_motor_pwm_driver;

    localparam int unsigned P = 100;
    localparam int unsigned D = 20;
    localparam int unsigned R = 25;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] width_in = '0;
    logic [3:0]  dir_in = '0;
    logic [3:0]  dir_out;
    logic        pwm_a, pwm_b, busy;
    logic [15:0] active_width;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .PERIOD      (P),
        .DEAD_CYCLES (D),
        .RAMP_STEP   (R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .width_in     (width_in),
        .dir_in       (dir_in),
        .dir_out      (dir_out),
        .pwm_a        (pwm_a),
        .pwm_b        (pwm_b),
        .active_width (active_width),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Reference model: mode 0 idle, 1 running, 2 blanked; phase = cycles since run start mod P.
    int m_mode, m_phase, m_width, m_dead_left, m_dir;
    int prev_dir;

    function automatic bit is_stop(input int d, input int w);
        return !(d == 5 || d == 6 || d == 9 || d == 10) || w == 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_width = 0; m_dead_left = 0; m_dir = 0;
    endtask

    task automatic model_edge(input int d, input int w);
        int tgt;
        tgt = (w > P) ? P : w;
        case (m_mode)
            0: if (!is_stop(d, w)) begin
                m_mode = 1; m_dir = d; m_width = 0; m_phase = 0;
            end
            1: begin
                if (is_stop(d, w)) begin
                    m_mode = 0; m_dir = 0; m_width = 0; m_phase = 0;
                end else if (d != m_dir) begin
                    m_mode = 2; m_dead_left = D; m_dir = 0; m_width = 0; m_phase = 0;
                end else if (m_phase == P - 1) begin
                    m_phase = 0;
                    if (tgt < m_width) m_width = tgt;
                    else m_width = (m_width + R > tgt) ? tgt : m_width + R;
                end else begin
                    m_phase++;
                end
            end
            default: begin
                m_dead_left--;
                if (m_dead_left == 0) begin
                    if (is_stop(d, w)) begin
                        m_mode = 0;
                    end else begin
                        m_mode = 1; m_dir = d; m_width = 0; m_phase = 0;
                    end
                end
            end
        endcase
    endtask

    task automatic compare_all();
        int exp_pwm;
        int direct;
        exp_pwm = (m_mode == 1 && m_phase < m_width) ? 1 : 0;
        check_eq("dir_out", int'(dir_out), m_dir);
        check_eq("active_width", int'(active_width), m_width);
        check_eq("pwm_a", int'(pwm_a), exp_pwm);
        check_eq("pwm_b", int'(pwm_b), exp_pwm);
        check_eq("busy", int'(busy), (m_mode == 2) ? 1 : 0);
        direct = (prev_dir != 0 && dir_out != 0 && int'(dir_out) != prev_dir) ? 1 : 0;
        check_eq("dir_direct_change", direct, 0);
        prev_dir = int'(dir_out);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_edge(int'(dir_in), int'(width_in));
            #1;
            compare_all();
        end
    endtask

    task automatic count_high(output int hi);
        hi = 0;
        repeat (P) begin
            step(1);
            hi += int'(pwm_a);
        end
    endtask

    // Pulse reset low between clock edges, checking outputs while it is held.
    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("async_rst_pwm", int'(pwm_a), 0);
        #1 rst_n = 1'b1;
    endtask

    int hi;
    int valid_dirs[4] = '{5, 6, 9, 10};

    initial begin
        model_reset();
        prev_dir = 0;
        #12;
        compare_all();
        rst_n = 1'b1;
        step(3);

        // Soft start
        dir_in = 4'b0110; width_in = 16'd80;
        step(1);
        check_eq("start_dir", int'(dir_out), 6);
        step(499);
        check_eq("ramp_final", int'(active_width), 80);
        count_high(hi);
        check_eq("duty80", hi, 80);

        // Reversal
        dir_in = 4'b1001;
        step(1);
        check_eq("rev_busy", int'(busy), 1);
        step(25);
        check_eq("rev_dir", int'(dir_out), 9);
        step(300);

        // Stop via each form of STOP command
        dir_in = 4'b1111;
        step(4);
        dir_in = 4'b1001; width_in = 16'd80;
        step(150);
        width_in = 16'd0;
        step(3);
        width_in = 16'd80;
        step(150);
        dir_in = 4'b0000;
        step(3);

        // Clamp and drop
        dir_in = 4'b1010; width_in = 16'd200;
        step(501);
        count_high(hi);
        check_eq("duty100", hi, 100);
        width_in = 16'd30;
        step(2 * P);
        check_eq("drop30", int'(active_width), 30);

        // Dead-time toggles ending in STOP, then ending in 1010
        dir_in = 4'b0101;
        step(1);
        for (int i = 0; i < int'(D) - 1; i++) begin
            dir_in = (i % 2 == 1) ? 4'b1010 : 4'b0101;
            step(1);
        end
        dir_in = 4'b0000;
        step(3);
        dir_in = 4'b0110; width_in = 16'd80;
        step(150);
        dir_in = 4'b0101;
        step(1);
        for (int i = 0; i < int'(D) - 1; i++) begin
            dir_in = (i % 2 == 1) ? 4'b0101 : 4'b1010;
            step(1);
        end
        dir_in = 4'b1010;
        step(1);
        check_eq("dead_end_dir", int'(dir_out), 10);
        step(50);

        // Async reset mid-RUN, then mid-DEAD with a command present at release
        dir_in = 4'b0000;
        reset_pulse();
        step(5);
        dir_in = 4'b0110; width_in = 16'd80;
        step(150);
        dir_in = 4'b1001;
        step(5);
        reset_pulse();
        step(200);

        // Random command stream
        repeat (40) begin
            int wsel;
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) wsel = 0;
            else if (r == 1) wsel = 65535;
            else if (r == 2) wsel = P;
            else wsel = int'($urandom_range(1, 150));
            width_in = 16'(wsel);
            if ($urandom_range(0, 3) == 0) dir_in = 4'($urandom_range(0, 15));
            else dir_in = 4'(valid_dirs[$urandom_range(0, 3)]);
            step(int'($urandom_range(1, 250)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/motor_pwm_driver.md
MOTOR_PWM_DRIVER -- requirements
Module: motor_pwm_driver

Downstream stage: consumes the 16-bit duty value and 4-bit H-bridge pattern produced by the IPS steering logic, and drives the H-bridge.

Interface
REQ-001 Parameter PERIOD, default 50000, PWM period in clk cycles (2 kHz at 100 MHz).
REQ-002 Parameter DEAD_CYCLES, default 100000, H-bridge dead time in clk cycles on a direction reversal.
REQ-003 Parameter RAMP_STEP, default 2000, maximum duty increase per PWM period.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 width_in  in  16  requested duty, in clk counts high per period.
REQ-007 dir_in  in  4  requested H-bridge pattern.
REQ-008 dir_out  out  4  registered H-bridge pattern to the motor driver pins.
REQ-009 pwm_a  out  1  enable PWM, left motor.
REQ-010 pwm_b  out  1  enable PWM, right motor; always equal to pwm_a.
REQ-011 active_width  out  16  duty currently applied.
REQ-012 busy  out  1  high while in dead time.

Function
REQ-013 The block SHALL treat only 0101, 0110, 1010 and 1001 as valid directions; any other dir_in, including 0000, or width_in == 0 is a STOP command.
REQ-014 The block SHALL clamp target duty to min(width_in, PERIOD); width_in >= PERIOD gives 100 % duty.
REQ-015 The block SHALL run a period counter 0..PERIOD-1 that wraps to 0 and is cleared to 0 on every entry to RUN.
REQ-016 pwm_a SHALL be registered, and high iff state == RUN and counter < active_width.
REQ-017 The FSM SHALL have states IDLE, RUN and DEAD.
REQ-018 IDLE: dir_out = 0000, active_width = 0, pwm low; a non-STOP command moves to RUN next cycle, with dir_out = dir_in and active_width = 0.
REQ-019 RUN, same dir_in as dir_out: at each wrap (counter == PERIOD-1), active_width SHALL increase by min(RAMP_STEP, target - active_width).
REQ-020 RUN, at each wrap with target < active_width: active_width SHALL drop to target, with no downward ramp.
REQ-021 active_width SHALL NOT change mid-period, except to 0 on STOP or on leaving RUN.
REQ-022 RUN, STOP command: the block SHALL go to IDLE next cycle, giving dir_out = 0000, pwm low and active_width = 0 one cycle after the input.
REQ-023 RUN, different valid dir_in: the block SHALL go to DEAD next cycle, with dir_out = 0000, pwm low, active_width = 0, and the dead counter loaded with DEAD_CYCLES-1.
REQ-024 DEAD: busy = 1 and the dead counter decrements each cycle; dir_in changes are ignored until the count reaches 0.
REQ-025 At dead counter 0, the block SHALL sample the command: non-STOP goes to RUN with dir_out = dir_in and the ramp from 0; STOP goes to IDLE.
REQ-026 dir_out SHALL never change directly from one non-zero pattern to another; at least one cycle of 0000 always separates them, and that gap is DEAD_CYCLES cycles on any reversal.
REQ-027 A STOP command SHALL always take priority over ramp and wrap events in the same cycle.
REQ-028 All arithmetic SHALL be unsigned; ramp addition SHALL saturate at the target and never overflow 16 bits.

Reset
REQ-029 While rst_n = 0, the block SHALL hold state IDLE, both counters 0, dir_out = 0000, pwm_a = pwm_b = 0, active_width = 0, busy = 0, asynchronously.
REQ-030 Reset asserted mid-RUN or mid-DEAD SHALL force the outputs to the values in REQ-029 immediately, without waiting for a clock edge.
REQ-031 After rst_n rises, the first command SHALL be evaluated on the next rising clk edge.

Verification (PERIOD=100, DEAD_CYCLES=20, RAMP_STEP=25)
REQ-032 Soft start: width_in = 80, dir_in = 0110 from IDLE -> dir_out = 0110 after 1 cycle; active_width steps 0, 25, 50, 75, 80 at successive wraps; pwm high exactly 80 of every 100 cycles thereafter.
REQ-033 Reversal: in RUN 0110 @ 80, dir_in -> 1001 -> next cycle dir_out = 0000, pwm low, busy = 1 for 20 cycles; then dir_out = 1001 and active_width restarts from 0 and ramps up.
REQ-034 Stop: in RUN, dir_in = 0000 (or width_in = 0, or dir_in = 1111) -> one cycle later dir_out = 0000, pwm = 0, active_width = 0, state IDLE.
REQ-035 Clamp and drop: width_in = 200 -> ramps to 100 and pwm stays constantly high; width_in -> 30 -> active_width = 30 at the next wrap and not before.
REQ-036 Dead-time command changes: during DEAD, dir_in toggles 1010/0101 and ends at 0000 -> IDLE at count 0 with dir_out = 0000 throughout; a second run ends at 1010 -> RUN with 1010.
REQ-037 Async reset: rst_n pulsed low for less than one clk period mid-RUN and mid-DEAD -> outputs 0 immediately; after release, the block stays in IDLE until a command arrives.
